nes_flash_rd: RTL and testbench

Read-only controller for the external parallel NOR flash that holds PRG ROM images. It sits directly downstream of the mapper stage. It accepts 23-bit byte addresses from the mapper's flash address output, runs timed chip-enable/output-enable read cycles on the flash pins, and returns the byte to the mapper's flash read-data input with a one-cycle acknowledge. It also sequences the flash reset pin after system reset.

---
 rtl/nes_flash_pkg.sv | 18 +
 rtl/nes_flash_linebuf.sv | 40 ++++
 rtl/nes_flash_rd.sv | 159 +++++++++++++++
 tb/tb_nes_flash_rd.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/nes_flash_pkg.sv
// Shared types and constants for the PRG ROM NOR flash read controller.
package nes_flash_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } fl_state_e;

  localparam int FL_ADDR_W  = 22;
  localparam int LINE_BYTES = 4;
  localparam int LINE_OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W      = FL_ADDR_W - LINE_OFF_W;

  localparam logic [7:0] OOR_DATA = 8'hFF;

endpackage

// File: rtl/nes_flash_linebuf.sv
// One-entry, 4-byte aligned line buffer: tag/valid, byte storage, hit compare.
module nes_flash_linebuf
  import nes_flash_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_inval,
  input  logic [TAG_W-1:0]      i_lookup_tag,
  output logic                  o_hit,
  input  logic [LINE_OFF_W-1:0] i_rd_idx,
  output logic [7:0]            o_rd_data,
  input  logic                  i_wr_en,
  input  logic [LINE_OFF_W-1:0] i_wr_idx,
  input  logic [7:0]            i_wr_data,
  input  logic                  i_fill_done,
  input  logic [TAG_W-1:0]      i_fill_tag
);

  logic [7:0]       mem_q [LINE_BYTES];
  logic [TAG_W-1:0] tag_q;
  logic             valid_q;

  // Valid only rises once every byte of the line has been written.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_inval) begin
      valid_q <= 1'b0;
    end else if (i_fill_done) begin
      valid_q <= 1'b1;
      tag_q   <= i_fill_tag;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_idx] <= i_wr_data;
  end

  assign o_hit     = valid_q && (tag_q == i_lookup_tag);
  assign o_rd_data = mem_q[i_rd_idx];

endmodule

// File: rtl/nes_flash_rd.sv
// Read-only NOR flash controller for PRG ROM: timed CE#/OE# byte reads, flash reset sequencing.
// Optional line buffer compiled in with `define NES_FLASH_LINEBUF_EN.
module nes_flash_rd
  import nes_flash_pkg::*;
#(
  parameter int WAIT_CYC = 7,
  parameter int RST_CYC  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic [22:0]          i_addr,
  output logic                 o_ack,
  output logic [7:0]           o_rdata,
  output logic                 o_busy,
  output logic [FL_ADDR_W-1:0] o_fl_addr,
  input  logic [7:0]           i_fl_dq,
  output logic                 o_fl_ce_n,
  output logic                 o_fl_oe_n,
  output logic                 o_fl_we_n,
  output logic                 o_fl_rst_n
);

  localparam int WCNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int RCNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  fl_state_e            state_q, state_d;
  logic [WCNT_W-1:0]    wcnt_q;
  logic [RCNT_W-1:0]    rcnt_q;
  logic [7:0]           rdata_q;
  logic [FL_ADDR_W-1:0] fl_addr_q;
  logic                 ack_q, busy_q, ce_n_q, oe_n_q, rst_n_q;
  logic                 wait_last, last_byte, oor, hit;

`ifdef NES_FLASH_LINEBUF_EN
  logic [LINE_OFF_W-1:0] bidx_q, off_q, lb_rd_idx;
  logic [7:0]            lb_rd_data, fill_byte;
  logic                  lb_wr, lb_inval;

  assign last_byte = (bidx_q == LINE_OFF_W'(LINE_BYTES - 1));
  assign lb_rd_idx = (state_q == ST_IDLE) ? i_addr[LINE_OFF_W-1:0] : off_q;
  assign lb_wr     = (state_q == ST_ACCESS) && wait_last && !i_rst;
  assign lb_inval  = (state_q == ST_IDLE) && i_req && !oor && !hit;
  // The final byte is written on the same edge it is returned, so bypass the storage for it.
  assign fill_byte = (off_q == bidx_q) ? i_fl_dq : lb_rd_data;

  nes_flash_linebuf u_linebuf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_inval      (lb_inval),
    .i_lookup_tag (i_addr[FL_ADDR_W-1:LINE_OFF_W]),
    .o_hit        (hit),
    .i_rd_idx     (lb_rd_idx),
    .o_rd_data    (lb_rd_data),
    .i_wr_en      (lb_wr),
    .i_wr_idx     (bidx_q),
    .i_wr_data    (i_fl_dq),
    .i_fill_done  (lb_wr && last_byte),
    .i_fill_tag   (fl_addr_q[FL_ADDR_W-1:LINE_OFF_W])
  );
`else
  assign last_byte = 1'b1;
  assign hit       = 1'b0;
`endif

  assign oor       = i_addr[22];
  assign wait_last = (wcnt_q == WCNT_W'(WAIT_CYC - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (rcnt_q == RCNT_W'(RST_CYC - 1)) state_d = ST_IDLE;
      ST_IDLE:   if (i_req) state_d = (oor || hit) ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (wait_last && last_byte) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
    if (i_rst) state_d = ST_INIT;
  end

  always_ff @(posedge i_clk) begin
    state_q <= state_d;
  end

  // Pin and status outputs are registered from the next state so they switch with the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      rdata_q   <= '0;
      fl_addr_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      rst_n_q   <= 1'b0;
`ifdef NES_FLASH_LINEBUF_EN
      bidx_q    <= '0;
      off_q     <= '0;
`endif
    end else begin
      ack_q   <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_IDLE);
      ce_n_q  <= (state_d != ST_ACCESS);
      oe_n_q  <= (state_d != ST_ACCESS);
      rst_n_q <= (state_d != ST_INIT);
      case (state_q)
        ST_INIT: rcnt_q <= rcnt_q + 1'b1;
        ST_IDLE: begin
          if (i_req) begin
            wcnt_q <= '0;
            if (oor) begin
              rdata_q <= OOR_DATA;
`ifdef NES_FLASH_LINEBUF_EN
            end else if (hit) begin
              rdata_q <= lb_rd_data;
            end else begin
              fl_addr_q <= {i_addr[FL_ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
              off_q     <= i_addr[LINE_OFF_W-1:0];
              bidx_q    <= '0;
`else
            end else begin
              fl_addr_q <= i_addr[FL_ADDR_W-1:0];
`endif
            end
          end
        end
        ST_ACCESS: begin
          if (wait_last) begin
            wcnt_q <= '0;
`ifdef NES_FLASH_LINEBUF_EN
            if (last_byte) begin
              rdata_q <= fill_byte;
            end else begin
              bidx_q    <= bidx_q + 1'b1;
              fl_addr_q <= fl_addr_q + 1'b1;
            end
`else
            rdata_q <= i_fl_dq;
`endif
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ack      = ack_q;
  assign o_rdata    = rdata_q;
  assign o_busy     = busy_q;
  assign o_fl_addr  = fl_addr_q;
  assign o_fl_ce_n  = ce_n_q;
  assign o_fl_oe_n  = oe_n_q;
  assign o_fl_we_n  = 1'b1;
  assign o_fl_rst_n = rst_n_q;

endmodule

// File: tb/tb_nes_flash_rd.sv
// Directed self-checking bench for nes_flash_rd with a combinational NOR flash model.
module tb_nes_flash_rd;

  localparam int W = 7;
  localparam int R = 16;
`ifdef NES_FLASH_LINEBUF_EN
  localparam int MISS_LAT = 4 * W + 1;
  localparam int MISS_OE  = 4 * W;
`else
  localparam int MISS_LAT = W + 1;
  localparam int MISS_OE  = W;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst, i_req;
  logic [22:0] i_addr;
  logic        o_ack, o_busy, o_fl_ce_n, o_fl_oe_n, o_fl_we_n, o_fl_rst_n;
  logic [7:0]  o_rdata, fl_dq;
  logic [21:0] o_fl_addr;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 i_clk = ~i_clk;

  nes_flash_rd #(.WAIT_CYC(W), .RST_CYC(R)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .o_ack      (o_ack),
    .o_rdata    (o_rdata),
    .o_busy     (o_busy),
    .o_fl_addr  (o_fl_addr),
    .i_fl_dq    (fl_dq),
    .o_fl_ce_n  (o_fl_ce_n),
    .o_fl_oe_n  (o_fl_oe_n),
    .o_fl_we_n  (o_fl_we_n),
    .o_fl_rst_n (o_fl_rst_n)
  );

  function automatic logic [7:0] fl_byte(input logic [21:0] a);
    if (a == 22'h000123) return 8'hA5;
    return a[7:0] ^ {a[13:8], 2'b01} ^ 8'h3C;
  endfunction

  assign fl_dq = (!o_fl_ce_n && !o_fl_oe_n) ? fl_byte(o_fl_addr) : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at the negedge where i_rst is released; returns at the first negedge with o_busy low.
  task automatic wait_idle(output int k, output int acks, output int rst_low);
    k = 1; acks = 0; rst_low = 0;
    while (o_busy !== 1'b0 && k < 64) begin
      if (o_ack) acks++;
      if (!o_fl_rst_n) rst_low++;
      @(negedge i_clk);
      k++;
    end
    i_req = 1'b0;
  endtask

  task automatic rd(input logic [22:0] a, input int exp_lat, input int exp_oe, input bit drop);
    int lat, oe_cnt, ce_cnt, addr_bad;
    bit got;
    logic [21:0] ea;
    logic [7:0]  ed;
    i_req = 1'b1; i_addr = a;
    lat = 0; oe_cnt = 0; ce_cnt = 0; addr_bad = 0; got = 0;
    while (!got && lat < 200) begin
      @(negedge i_clk);
      lat++;
      if (!o_fl_ce_n) ce_cnt++;
      if (!o_fl_oe_n) begin
        ea = (exp_oe > W) ? ({a[21:2], 2'b00} + 22'(oe_cnt / W)) : a[21:0];
        if (o_fl_addr !== ea || o_fl_ce_n !== 1'b0) addr_bad++;
        oe_cnt++;
      end
      if (o_ack === 1'b1) got = 1;
    end
    ed = a[22] ? 8'hFF : fl_byte(a[21:0]);
    check($sformatf("ack_lat_%06h", a), lat, exp_lat);
    check($sformatf("oe_cycles_%06h", a), oe_cnt, exp_oe);
    check($sformatf("ce_cycles_%06h", a), ce_cnt, exp_oe);
    check($sformatf("pin_addr_%06h", a), addr_bad, 0);
    check($sformatf("rdata_%06h", a), o_rdata, ed);
    if (drop) i_req = 1'b0;
  endtask

  initial begin
    int k, acks, rlow;
    bit ack_seen;
    i_rst = 1'b1; i_req = 1'b0; i_addr = '0;
    repeat (3) @(negedge i_clk);
    check("rst_ack", o_ack, 0);
    check("rst_rdata", o_rdata, 8'h00);
    check("rst_busy", o_busy, 1);
    check("rst_fl_addr", o_fl_addr, 0);
    check("rst_ce_n", o_fl_ce_n, 1);
    check("rst_oe_n", o_fl_oe_n, 1);
    check("rst_we_n", o_fl_we_n, 1);
    check("rst_fl_rst_n", o_fl_rst_n, 0);

    // Release with a request held through INIT: it must be ignored there.
    i_rst = 1'b0; i_req = 1'b1; i_addr = 23'h000050;
    wait_idle(k, acks, rlow);
    check("init_idle_cycle", k, R + 1);
    check("init_rst_low_cycles", rlow, R);
    check("init_no_ack", acks, 0);
    check("init_fl_rst_n_high", o_fl_rst_n, 1);
    @(negedge i_clk);

    rd(23'h000123, MISS_LAT, MISS_OE, 1);
    @(negedge i_clk);
    check("fl_addr_hold_idle", o_fl_addr, (MISS_OE > W) ? 22'h000123 : 22'h000123);
    rd(23'h400000, 2 - 1, 0, 1);
    @(negedge i_clk);

    // Reset in the middle of an access.
    i_req = 1'b1; i_addr = 23'h000200; ack_seen = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_ack) ack_seen = 1;
    end
    check("midrst_in_access_oe", o_fl_oe_n, 0);
    i_rst = 1'b1; i_req = 1'b0;
    @(negedge i_clk);
    check("midrst_ce_n", o_fl_ce_n, 1);
    check("midrst_oe_n", o_fl_oe_n, 1);
    check("midrst_fl_rst_n", o_fl_rst_n, 0);
    i_rst = 1'b0;
    wait_idle(k, acks, rlow);
    check("midrst_no_ack", acks + int'(ack_seen), 0);
    check("midrst_idle_cycle", k, R + 1);
    @(negedge i_clk);
    rd(23'h000200, MISS_LAT, MISS_OE, 1);
    @(negedge i_clk);

    // Back-to-back with i_req held high: first from IDLE, then one ack every MISS_LAT+1 cycles.
    rd(23'h000010, MISS_LAT, MISS_OE, 0);
    rd(23'h000021, MISS_LAT + 1, MISS_OE, 0);
    rd(23'h1ABC42, MISS_LAT + 1, MISS_OE, 0);
    rd(23'h3FFFFF, MISS_LAT + 1, MISS_OE, 1);
    @(negedge i_clk);

`ifdef NES_FLASH_LINEBUF_EN
    rd(23'h000100, 4 * W + 1, 4 * W, 1);
    @(negedge i_clk);
    rd(23'h000102, 1, 0, 1);
    @(negedge i_clk);
    rd(23'h400102, 1, 0, 1);
    @(negedge i_clk);
    rd(23'h000103, 1, 0, 1);
    @(negedge i_clk);
    rd(23'h000104, 4 * W + 1, 4 * W, 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    wait_idle(k, acks, rlow);
    @(negedge i_clk);
    rd(23'h000100, 4 * W + 1, 4 * W, 1);
    @(negedge i_clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
